// File: rtl/mem_access_stage_pkg.sv
// Shared encodings and store-lane helpers for the MEM pipeline stage.
// Memory access size codes, write-back source codes and FSM states live here.
package mem_access_stage_pkg;

  localparam int MEM_SIZE_LENGTH = 2;
  localparam logic [MEM_SIZE_LENGTH-1:0] MEM_SIZE_BYTE = 2'd0;
  localparam logic [MEM_SIZE_LENGTH-1:0] MEM_SIZE_HALF = 2'd1;
  localparam logic [MEM_SIZE_LENGTH-1:0] MEM_SIZE_WORD = 2'd2;

  localparam int WDATA_SRC_LENGTH = 2;
  localparam logic [WDATA_SRC_LENGTH-1:0] WDATA_SRC_ALU = 2'd0;
  localparam logic [WDATA_SRC_LENGTH-1:0] WDATA_SRC_MEM = 2'd1;
  localparam logic [WDATA_SRC_LENGTH-1:0] WDATA_SRC_PC8 = 2'd2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  function automatic logic is_misaligned(input logic [MEM_SIZE_LENGTH-1:0] size,
                                         input logic [1:0] lo);
    return ((size == MEM_SIZE_HALF) && lo[0]) ||
           ((size == MEM_SIZE_WORD) && (lo != 2'b00));
  endfunction

  function automatic logic [3:0] store_be(input logic [MEM_SIZE_LENGTH-1:0] size,
                                          input logic [1:0] lo);
    logic [3:0] be;
    be = 4'b1111;
    if (size == MEM_SIZE_BYTE)      be = 4'b0001 << lo;
    else if (size == MEM_SIZE_HALF) be = lo[1] ? 4'b1100 : 4'b0011;
    return be;
  endfunction

  // Narrow stores are replicated so the byte enables alone pick the lane.
  function automatic logic [31:0] store_wdata(input logic [MEM_SIZE_LENGTH-1:0] size,
                                              input logic [31:0] data);
    logic [31:0] w;
    w = data;
    if (size == MEM_SIZE_BYTE)      w = {4{data[7:0]}};
    else if (size == MEM_SIZE_HALF) w = {2{data[15:0]}};
    return w;
  endfunction

endpackage

// File: rtl/mem_access_stage_load_align.sv
// Load data aligner: picks the addressed byte/half of the read word and
// sign- or zero-extends it to 32 bits.
module load_align
  import mem_access_stage_pkg::*;
(
  input  logic [31:0]                rdata_i,
  input  logic [1:0]                 addr_lo_i,
  input  logic [MEM_SIZE_LENGTH-1:0] size_i,
  input  logic                       unsigned_i,
  output logic [31:0]                data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (size_i)
      MEM_SIZE_BYTE: data_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
      MEM_SIZE_HALF: data_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
      default:       data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues data-memory requests over req/ack, stalls the
// front of the pipe while an access is outstanding and registers MEM/WB.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ex_valid,
  input  logic [31:0]                 ex_alu_res,
  input  logic [31:0]                 ex_store_data,
  input  logic                        ex_mem_read,
  input  logic                        ex_mem_write,
  input  logic [MEM_SIZE_LENGTH-1:0]  ex_mem_size,
  input  logic                        ex_mem_unsigned,
  input  logic [4:0]                  ex_reg_dst,
  input  logic                        ex_reg_write,
  input  logic [WDATA_SRC_LENGTH-1:0] ex_wdata_src,
  input  logic [31:0]                 ex_pc_plus8,
  output logic                        dmem_req,
  output logic                        dmem_we,
  output logic [31:0]                 dmem_addr,
  output logic [31:0]                 dmem_wdata,
  output logic [3:0]                  dmem_be,
  input  logic                        dmem_ack,
  input  logic [31:0]                 dmem_rdata,
  output logic                        mem_stall,
  output logic                        wb_valid,
  output logic                        wb_reg_write,
  output logic [31:0]                 wb_alu_res,
  output logic [31:0]                 wb_mem_data,
  output logic [31:0]                 wb_pc_plus8,
  output logic [4:0]                  wb_reg_dst,
  output logic [WDATA_SRC_LENGTH-1:0] wb_wdata_src,
  output logic                        mem_addr_err,
  output logic                        mem_bus_err
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [31:0]                 addr_q, addr_d;
  logic [31:0]                 wdata_q, wdata_d;
  logic [3:0]                  be_q, be_d;
  logic                        we_q, we_d;
  logic [MEM_SIZE_LENGTH-1:0]  size_q, size_d;
  logic                        uns_q, uns_d;
  logic [4:0]                  rd_q, rd_d;
  logic                        regw_q, regw_d;
  logic [WDATA_SRC_LENGTH-1:0] wsrc_q, wsrc_d;
  logic [31:0]                 pc8_q, pc8_d;

  logic                        wb_valid_q, wb_valid_d;
  logic                        wb_regw_q, wb_regw_d;
  logic [31:0]                 wb_alu_q, wb_alu_d;
  logic [31:0]                 wb_mem_q, wb_mem_d;
  logic [31:0]                 wb_pc8_q, wb_pc8_d;
  logic [4:0]                  wb_rd_q, wb_rd_d;
  logic [WDATA_SRC_LENGTH-1:0] wb_wsrc_q, wb_wsrc_d;
  logic                        addr_err_q, addr_err_d;
  logic                        bus_err_q, bus_err_d;

  logic [31:0] load_data;
  logic        is_mem;

  load_align u_load_align (
    .rdata_i    (dmem_rdata),
    .addr_lo_i  (addr_q[1:0]),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .data_o     (load_data)
  );

  assign is_mem     = ex_mem_read | ex_mem_write;
  assign dmem_req   = (state_q == ST_WAIT);
  assign dmem_we    = dmem_req & we_q;
  assign dmem_be    = dmem_req ? be_q : 4'b0000;
  assign dmem_addr  = {addr_q[31:2], 2'b00};
  assign dmem_wdata = wdata_q;

  assign wb_valid     = wb_valid_q;
  assign wb_reg_write = wb_regw_q;
  assign wb_alu_res   = wb_alu_q;
  assign wb_mem_data  = wb_mem_q;
  assign wb_pc_plus8  = wb_pc8_q;
  assign wb_reg_dst   = wb_rd_q;
  assign wb_wdata_src = wb_wsrc_q;
  assign mem_addr_err = addr_err_q;
  assign mem_bus_err  = bus_err_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    we_d       = we_q;
    size_d     = size_q;
    uns_d      = uns_q;
    rd_d       = rd_q;
    regw_d     = regw_q;
    wsrc_d     = wsrc_q;
    pc8_d      = pc8_q;
    wb_valid_d = 1'b0;
    wb_regw_d  = 1'b0;
    addr_err_d = 1'b0;
    bus_err_d  = 1'b0;
    wb_alu_d   = wb_alu_q;
    wb_mem_d   = wb_mem_q;
    wb_pc8_d   = wb_pc8_q;
    wb_rd_d    = wb_rd_q;
    wb_wsrc_d  = wb_wsrc_q;
    mem_stall  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (ex_valid && is_mem && !is_misaligned(ex_mem_size, ex_alu_res[1:0])) begin
          addr_d    = ex_alu_res;
          wdata_d   = store_wdata(ex_mem_size, ex_store_data);
          be_d      = ex_mem_write ? store_be(ex_mem_size, ex_alu_res[1:0]) : 4'b1111;
          we_d      = ex_mem_write;
          size_d    = ex_mem_size;
          uns_d     = ex_mem_unsigned;
          rd_d      = ex_reg_dst;
          regw_d    = ex_reg_write & ~ex_mem_write;
          wsrc_d    = ex_wdata_src;
          pc8_d     = ex_pc_plus8;
          cnt_d     = '0;
          state_d   = ST_WAIT;
          mem_stall = 1'b1;
        end else if (ex_valid) begin
          wb_valid_d = 1'b1;
          wb_regw_d  = ex_reg_write & ~is_mem;
          addr_err_d = is_mem;
          wb_alu_d   = ex_alu_res;
          wb_mem_d   = '0;
          wb_pc8_d   = ex_pc_plus8;
          wb_rd_d    = ex_reg_dst;
          wb_wsrc_d  = ex_wdata_src;
        end
      end

      // The timeout cycle also releases the stall, otherwise the abandoned
      // instruction would still sit in EX/MEM and be issued a second time.
      ST_WAIT: begin
        if (dmem_ack || (cnt_q == CNT_LAST)) begin
          state_d    = ST_IDLE;
          wb_valid_d = 1'b1;
          wb_regw_d  = regw_q & dmem_ack;
          bus_err_d  = ~dmem_ack;
          wb_alu_d   = addr_q;
          wb_mem_d   = (dmem_ack && !we_q) ? load_data : 32'd0;
          wb_pc8_d   = pc8_q;
          wb_rd_d    = rd_q;
          wb_wsrc_d  = wsrc_q;
        end else begin
          cnt_d     = cnt_q + CNT_W'(1);
          mem_stall = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      we_q       <= 1'b0;
      size_q     <= '0;
      uns_q      <= 1'b0;
      rd_q       <= '0;
      regw_q     <= 1'b0;
      wsrc_q     <= '0;
      pc8_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_regw_q  <= 1'b0;
      wb_alu_q   <= '0;
      wb_mem_q   <= '0;
      wb_pc8_q   <= '0;
      wb_rd_q    <= '0;
      wb_wsrc_q  <= '0;
      addr_err_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      we_q       <= we_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      rd_q       <= rd_d;
      regw_q     <= regw_d;
      wsrc_q     <= wsrc_d;
      pc8_q      <= pc8_d;
      wb_valid_q <= wb_valid_d;
      wb_regw_q  <= wb_regw_d;
      wb_alu_q   <= wb_alu_d;
      wb_mem_q   <= wb_mem_d;
      wb_pc8_q   <= wb_pc8_d;
      wb_rd_q    <= wb_rd_d;
      wb_wsrc_q  <= wb_wsrc_d;
      addr_err_q <= addr_err_d;
      bus_err_q  <= bus_err_d;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: a retirement queue predicts every
// MEM/WB result, and bus-side behaviour is checked as each access runs.
`timescale 1ns/1ps
module tb_mem_access_stage;
  import mem_access_stage_pkg::*;

  localparam int TO = 4;

  logic                        clk = 1'b0;
  logic                        rst_n = 1'b0;
  logic                        ex_valid, ex_mem_read, ex_mem_write, ex_mem_unsigned, ex_reg_write;
  logic [31:0]                 ex_alu_res, ex_store_data, ex_pc_plus8;
  logic [MEM_SIZE_LENGTH-1:0]  ex_mem_size;
  logic [4:0]                  ex_reg_dst;
  logic [WDATA_SRC_LENGTH-1:0] ex_wdata_src;
  logic                        dmem_req, dmem_we, dmem_ack;
  logic [31:0]                 dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]                  dmem_be;
  logic                        mem_stall, wb_valid, wb_reg_write, mem_addr_err, mem_bus_err;
  logic [31:0]                 wb_alu_res, wb_mem_data, wb_pc_plus8;
  logic [4:0]                  wb_reg_dst;
  logic [WDATA_SRC_LENGTH-1:0] wb_wdata_src;

  mem_access_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_alu_res(ex_alu_res),
    .ex_store_data(ex_store_data), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_size(ex_mem_size), .ex_mem_unsigned(ex_mem_unsigned), .ex_reg_dst(ex_reg_dst),
    .ex_reg_write(ex_reg_write), .ex_wdata_src(ex_wdata_src), .ex_pc_plus8(ex_pc_plus8),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .mem_stall(mem_stall),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_alu_res(wb_alu_res),
    .wb_mem_data(wb_mem_data), .wb_pc_plus8(wb_pc_plus8), .wb_reg_dst(wb_reg_dst),
    .wb_wdata_src(wb_wdata_src), .mem_addr_err(mem_addr_err), .mem_bus_err(mem_bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        isLoad, isStore, uns, regWrite;
    logic [1:0]  size, wsrc;
    logic [4:0]  rd;
    logic [31:0] addr, sdata, rdata, pc8;
    int          ackDelay;
  } instr_t;

  typedef struct {
    logic        regWrite, addrErr, busErr;
    logic [4:0]  rd;
    logic [1:0]  wsrc;
    logic [31:0] alu, mem, pc8;
  } exp_t;

  exp_t        expQ[$];
  exp_t        cmpE;
  int          vectors = 0;
  int          errors = 0;
  int          reqCycles, stallCycles;
  logic [31:0] seenWdata;
  logic [3:0]  seenBe;
  logic        seenWe;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  function automatic instr_t mkI(input logic ld, input logic st, input logic [1:0] size,
                                 input logic uns, input logic [31:0] addr, input logic [31:0] sdata,
                                 input logic [31:0] rdata, input logic [4:0] rd, input logic rw,
                                 input logic [1:0] wsrc, input logic [31:0] pc8, input int ackDelay);
    instr_t i;
    i.isLoad = ld; i.isStore = st; i.size = size; i.uns = uns; i.addr = addr;
    i.sdata = sdata; i.rdata = rdata; i.rd = rd; i.regWrite = rw; i.wsrc = wsrc;
    i.pc8 = pc8; i.ackDelay = ackDelay;
    return i;
  endfunction

  // Load result from plain shifts/masks; sign extension via (v ^ msb) - msb.
  function automatic logic [31:0] modelLoad(input instr_t i);
    logic [31:0] v;
    v = i.rdata;
    if (i.size == MEM_SIZE_BYTE) begin
      v = (i.rdata >> (8 * int'(i.addr[1:0]))) & 32'hFF;
      if (!i.uns) v = (v ^ 32'h80) - 32'h80;
    end else if (i.size == MEM_SIZE_HALF) begin
      v = (i.rdata >> (16 * int'(i.addr[1]))) & 32'hFFFF;
      if (!i.uns) v = (v ^ 32'h8000) - 32'h8000;
    end
    return v;
  endfunction

  function automatic logic [3:0] modelBe(input instr_t i);
    if (i.isLoad || i.size == MEM_SIZE_WORD) return 4'hF;
    if (i.size == MEM_SIZE_BYTE) return 4'(1 << int'(i.addr[1:0]));
    return 4'(3 << (2 * int'(i.addr[1])));
  endfunction

  function automatic logic [31:0] modelWdata(input instr_t i);
    if (i.size == MEM_SIZE_BYTE) return {24'd0, i.sdata[7:0]} * 32'h0101_0101;
    if (i.size == MEM_SIZE_HALF) return {16'd0, i.sdata[15:0]} * 32'h0001_0001;
    return i.sdata;
  endfunction

  task automatic applyStimulus(input instr_t in);
    exp_t e;
    bit   isMem, mis, done;
    isMem = in.isLoad || in.isStore;
    mis   = isMem && ((in.size == MEM_SIZE_HALF && in.addr % 2 != 0) ||
                      (in.size == MEM_SIZE_WORD && in.addr % 4 != 0));
    e.rd = in.rd; e.alu = in.addr; e.pc8 = in.pc8; e.wsrc = in.wsrc;
    e.addrErr = mis;
    e.busErr  = isMem && !mis && in.ackDelay >= TO;
    e.regWrite = in.regWrite && !mis && !in.isStore && !e.busErr;
    e.mem = (in.isLoad && !mis && !e.busErr) ? modelLoad(in) : 32'd0;
    expQ.push_back(e);

    ex_valid = 1'b1; ex_alu_res = in.addr; ex_store_data = in.sdata;
    ex_mem_read = in.isLoad; ex_mem_write = in.isStore; ex_mem_size = in.size;
    ex_mem_unsigned = in.uns; ex_reg_dst = in.rd; ex_reg_write = in.regWrite;
    ex_wdata_src = in.wsrc; ex_pc_plus8 = in.pc8; dmem_ack = 1'b0;
    #1;
    checkOutput("idle_req", dmem_req, 0);
    checkOutput("idle_stall", mem_stall, isMem && !mis);
    stallCycles = int'(mem_stall);
    reqCycles = 0;
    @(posedge clk); #1;
    if (isMem && !mis) begin
      done = 0;
      for (int k = 0; k < TO + 2 && !done; k++) begin
        if (k == in.ackDelay) begin
          dmem_ack = 1'b1;
          dmem_rdata = in.rdata;
        end
        #1;
        checkOutput("wait_req", dmem_req, 1);
        checkOutput("wait_addr", dmem_addr, in.addr & 32'hFFFF_FFFC);
        checkOutput("wait_we", dmem_we, in.isStore);
        checkOutput("wait_be", dmem_be, modelBe(in));
        if (in.isStore) checkOutput("wait_wdata", dmem_wdata, modelWdata(in));
        checkOutput("wait_stall", mem_stall, (k != in.ackDelay) && (k != TO - 1));
        seenWdata = dmem_wdata; seenBe = dmem_be; seenWe = dmem_we;
        reqCycles++;
        stallCycles += int'(mem_stall);
        done = (k == in.ackDelay) || (k == TO - 1);
        @(posedge clk); #1;
        dmem_ack = 1'b0;
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (wb_valid) begin
        if (expQ.size() == 0) begin
          vectors++;
          errors++;
          $display("[TB] FAIL extra_retire: got wb_valid=1, expected 0");
        end else begin
          cmpE = expQ.pop_front();
          checkOutput("wb_reg_write", wb_reg_write, cmpE.regWrite);
          checkOutput("wb_reg_dst", wb_reg_dst, cmpE.rd);
          checkOutput("wb_alu_res", wb_alu_res, cmpE.alu);
          checkOutput("wb_mem_data", wb_mem_data, cmpE.mem);
          checkOutput("wb_pc_plus8", wb_pc_plus8, cmpE.pc8);
          checkOutput("wb_wdata_src", wb_wdata_src, cmpE.wsrc);
          checkOutput("mem_addr_err", mem_addr_err, cmpE.addrErr);
          checkOutput("mem_bus_err", mem_bus_err, cmpE.busErr);
        end
      end else begin
        checkOutput("bubble_reg_write", wb_reg_write, 0);
        checkOutput("bubble_addr_err", mem_addr_err, 0);
        checkOutput("bubble_bus_err", mem_bus_err, 0);
      end
    end
  end

  initial begin
    ex_valid = 0; ex_alu_res = 0; ex_store_data = 0; ex_mem_read = 0; ex_mem_write = 0;
    ex_mem_size = MEM_SIZE_WORD; ex_mem_unsigned = 0; ex_reg_dst = 0; ex_reg_write = 0;
    ex_wdata_src = WDATA_SRC_ALU; ex_pc_plus8 = 0; dmem_ack = 0; dmem_rdata = 0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_req", dmem_req, 0);
    checkOutput("rst_be", dmem_be, 0);
    checkOutput("rst_addr", dmem_addr, 0);
    checkOutput("rst_wb_valid", wb_valid, 0);
    checkOutput("rst_wb_mem", wb_mem_data, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    applyStimulus(mkI(1, 0, MEM_SIZE_BYTE, 0, 32'h1003, 0, 32'h80FF_1234, 5'd2, 1, WDATA_SRC_MEM, 32'h100, 1));
    checkOutput("lb_literal", wb_mem_data, 32'hFFFF_FF80);
    checkOutput("lb_stall_cycles", stallCycles, 2);
    applyStimulus(mkI(1, 0, MEM_SIZE_BYTE, 1, 32'h1003, 0, 32'h80FF_1234, 5'd3, 1, WDATA_SRC_MEM, 32'h108, 0));
    checkOutput("lbu_literal", wb_mem_data, 32'h0000_0080);
    applyStimulus(mkI(0, 1, MEM_SIZE_HALF, 0, 32'h2002, 32'h0000_BEEF, 0, 5'd0, 0, WDATA_SRC_ALU, 32'h110, 0));
    checkOutput("sh_wdata_literal", seenWdata, 32'hBEEF_BEEF);
    checkOutput("sh_be_literal", seenBe, 4'b1100);
    checkOutput("sh_we_literal", seenWe, 1);
    checkOutput("sh_reg_write", wb_reg_write, 0);
    applyStimulus(mkI(1, 0, MEM_SIZE_WORD, 0, 32'h0006, 0, 32'h1111_1111, 5'd4, 1, WDATA_SRC_MEM, 32'h118, 0));
    checkOutput("misalign_err_literal", mem_addr_err, 1);
    checkOutput("misalign_no_req", reqCycles, 0);
    checkOutput("misalign_reg_write", wb_reg_write, 0);
    applyStimulus(mkI(1, 0, MEM_SIZE_WORD, 0, 32'h0040, 0, 32'h2222_2222, 5'd5, 1, WDATA_SRC_MEM, 32'h120, 99));
    checkOutput("timeout_err_literal", mem_bus_err, 1);
    checkOutput("timeout_req_cycles", reqCycles, TO);
    checkOutput("timeout_reg_write", wb_reg_write, 0);
    applyStimulus(mkI(1, 0, MEM_SIZE_WORD, 0, 32'h0044, 0, 32'h3333_4444, 5'd6, 1, WDATA_SRC_MEM, 32'h128, TO - 1));
    checkOutput("ack_at_timeout_literal", wb_mem_data, 32'h3333_4444);
    applyStimulus(mkI(1, 0, MEM_SIZE_HALF, 0, 32'h0302, 0, 32'h8001_7FFF, 5'd7, 1, WDATA_SRC_MEM, 32'h130, 2));
    checkOutput("lh_literal", wb_mem_data, 32'hFFFF_8001);
    applyStimulus(mkI(1, 0, MEM_SIZE_HALF, 1, 32'h0300, 0, 32'h8001_7FFF, 5'd8, 1, WDATA_SRC_MEM, 32'h138, 0));
    applyStimulus(mkI(0, 1, MEM_SIZE_BYTE, 0, 32'h0401, 32'h1234_56AB, 0, 5'd0, 0, WDATA_SRC_ALU, 32'h140, 1));
    checkOutput("sb_wdata_literal", seenWdata, 32'hABAB_ABAB);
    checkOutput("sb_be_literal", seenBe, 4'b0010);
    applyStimulus(mkI(0, 1, MEM_SIZE_WORD, 0, 32'h0408, 32'hDEAD_BEEF, 0, 5'd0, 0, WDATA_SRC_ALU, 32'h148, 0));

    applyStimulus(mkI(0, 0, MEM_SIZE_WORD, 0, 32'h0000_0010, 0, 0, 5'd3, 1, WDATA_SRC_ALU, 32'h200, 0));
    applyStimulus(mkI(1, 0, MEM_SIZE_WORD, 0, 32'h0000_0020, 0, 32'hCAFE_F00D, 5'd4, 1, WDATA_SRC_MEM, 32'h208, 0));
    applyStimulus(mkI(0, 0, MEM_SIZE_WORD, 0, 32'h0000_0214, 0, 0, 5'd31, 1, WDATA_SRC_PC8, 32'h210, 0));
    checkOutput("jal_pc8_literal", wb_pc_plus8, 32'h210);
    checkOutput("jal_wsrc_literal", wb_wdata_src, WDATA_SRC_PC8);

    ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("queue_drained", expQ.size(), 0);

    // Reset in the middle of a WAIT; the late ack must not retire anything.
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_mem_size = MEM_SIZE_WORD; ex_alu_res = 32'h0500;
    @(posedge clk); #1;
    ex_valid = 1'b0; ex_mem_read = 1'b0;
    checkOutput("pre_reset_req", dmem_req, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("reset_req", dmem_req, 0);
    checkOutput("reset_be", dmem_be, 0);
    checkOutput("reset_addr", dmem_addr, 0);
    checkOutput("reset_wb_alu", wb_alu_res, 0);
    checkOutput("reset_stall", mem_stall, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    dmem_ack = 1'b1; dmem_rdata = 32'h5555_5555;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    checkOutput("late_ack_wb_valid", wb_valid, 0);
    checkOutput("late_ack_req", dmem_req, 0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("final_queue_empty", expQ.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
